ipsxe_fft_bitrev_pingpong_ctrl: RTL and testbench
=================================================

# ipsxe_fft_bitrev_pingpong_ctrl

Ping-pong input buffer controller for the FFT core. Writes natural-order samples from an upstream stream into one half of a distributed SDPRAM while the other half is read out to the butterfly pipeline in bit-reversed order, sustaining one sample per cycle on both sides. Sits between the input adapter and the first radix-2 stage and owns the only instance of the distributed SDPRAM in that path.

## Interface
- ADDR_WIDTH, 6, log2 of frame length N; range 3–10
- DATA_WIDTH, 32, sample width (packed re/im); range 2–256
- i_aclk  in  1  single clock, drives all logic and both SDPRAM ports
- i_aresetn  in  1  reset, asynchronous, active-low
- s_valid  in  1  input sample valid
- s_ready  out  1  input sample accept
- s_data  in  DATA_WIDTH  input sample, natural order
- s_last  in  1  frame marker, expected on sample N-1
- m_valid  out  1  output sample valid
- m_ready  in  1  downstream accept
- m_data  out  DATA_WIDTH  output sample, registered
- m_last  out  1  high with the final sample of each frame
- o_err_last  out  1  one-cycle pulse on an s_last mismatch

## Operation
- Memory is 2·N words, {bank, index} addressing with the bank as MSB; SDPRAM has a combinational read path (OUT_REG=0).
- Status: full[1:0], one flag per bank. Write side sets a flag; read side clears it. The two sides never touch the same bank's flag in the same cycle.
- Write side: wr_bank, wr_cnt[ADDR_WIDTH-1:0]. s_ready = ~full[wr_bank].
  - On a handshake, write s_data to {wr_bank, wr_cnt} and increment wr_cnt.
  - When wr_cnt == N-1: set full[wr_bank], toggle wr_bank, wrap wr_cnt to 0.
- s_last check: if s_last != (wr_cnt == N-1) on a handshake, pulse o_err_last. Counting is unaffected, so framing is always by count.
- Read side FSM, two states:
  - IDLE → RUN when full[rd_bank].
  - RUN → IDLE after the sample with rd_cnt == N-1 is loaded, and full[rd_bank] is clear after the toggle.
  - RUN → RUN when the next bank is already full; no bubble between frames.
- Load condition: state RUN and (~m_valid | m_ready).
  - Load m_data from address {rd_bank, bitrev(rd_cnt)}, set m_valid, set m_last = (rd_cnt == N-1), increment rd_cnt.
  - On the N-1 load: clear full[rd_bank], toggle rd_bank.
- When m_valid is high and m_ready is low, m_data and m_last hold.
- m_valid drops when m_ready is high and no load occurs that cycle.
- Simultaneous events:
  - A write completing bank X and a read freeing bank Y in the same cycle both take effect.
  - A freed bank is writable (s_ready=1) in the following cycle.
- Reset mid-frame discards all buffered data; there is no flush handshake.

## Timing
- Reset values:
  - full = 0, wr_bank = rd_bank = 0, counters = 0, FSM = IDLE.
  - m_valid = 0, m_data = 0, m_last = 0, o_err_last = 0.
  - s_ready = 1 while held in reset and immediately after.
- Latency: the last input handshake of a frame occurs at edge E. m_valid is high after edge E+1 with sample bitrev(0) = index 0.
- Throughput: N samples per N cycles on each side with m_ready held high; continuous frames have no gaps.
- Backpressure: with both banks full, s_ready stays low until the read side's N-1 load.

## Configuration
- IPSXE_FFT_BITREV_EN
  - Defined: read address index = bit-reverse of rd_cnt.
  - Undefined: read index = rd_cnt, giving a plain natural-order ping-pong FIFO. All other behaviour and timing are unchanged.

## Structure
- Package ipsxe_fft_bitrev_pkg holds:
  - the bitrev function, parameterised on ADDR_WIDTH;
  - FSM state localparams IDLE/RUN;
  - the bank-select bit position constant.
- One sub-module: ipsxe_fft_distributed_sdpram_v1_2, instantiated with:
  - ADDR_WIDTH+1 and DATA_WIDTH;
  - OUT_REG=0, INIT_FILE="NONE";
  - wr_clk = rd_clk = i_aclk, rd_en = 1, rst = 0.
- Remaining logic lives in the controller: write counter, read FSM/counter, output register.

## Test plan
All scenarios use ADDR_WIDTH=3 (N=8).
- Single frame, BITREV_EN defined: write 0..7, m_ready=1 → m_data = 0,4,2,6,1,5,3,7; m_last only on 7; m_valid rises after edge E+1.
- Macro undefined, same stimulus → m_data = 0..7 in order.
- Three back-to-back frames with continuous s_valid and m_ready → s_ready never drops; 24 outputs with no m_valid gap between frames.
- m_ready=0 throughout, 20 input attempts → exactly 16 accepted; s_ready low from sample 16 on. Releasing m_ready then drains 16 correct outputs.
- s_last on sample 5 and missing on sample 7 → o_err_last pulses twice; output order unchanged.
- Assert i_aresetn low mid-read (after 3 outputs) → m_valid = 0 and s_ready = 1 immediately; the next frame reads out correctly from bank 0.

Source files
------------

// File: rtl/ipsxe_fft_bitrev_pkg.sv
// Shared definitions for the FFT bit-reversal ping-pong input buffer:
// read-side FSM states, bank-select position and the index bit-reverse helper.
package ipsxe_fft_bitrev_pkg;

  // Widest frame index the controller supports (N up to 1024).
  localparam int MAX_ADDR_WIDTH = 10;

  // The bank-select bit sits this many places below the buffer address MSB,
  // i.e. the buffer address is {bank, index}.
  localparam int BANK_SEL_POS_FROM_MSB = 0;

  // Read-side sequencing states.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } rd_state_e;

  // Mirror the low 'width' bits of idx; bits at and above 'width' return 0.
  function automatic logic [MAX_ADDR_WIDTH-1:0] bitrev(
    input logic [MAX_ADDR_WIDTH-1:0] idx,
    input int                        width
  );
    logic [MAX_ADDR_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_ADDR_WIDTH; i++) begin
      if (i < width) r[i] = idx[width-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/ipsxe_fft_distributed_sdpram_v1_2.sv
// Simple dual-port distributed RAM: synchronous write port, read port either
// combinational (OUT_REG=0) or registered (OUT_REG!=0). Initialisation files
// are not supported by this model; INIT_FILE must stay "NONE".
module ipsxe_fft_distributed_sdpram_v1_2 #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32,
  parameter int OUT_REG    = 0,
  parameter     INIT_FILE  = "NONE"
) (
  input  logic                  wr_clk,
  input  logic                  rd_clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];

  // Write port: store one word per enabled cycle.
  // NOTE: state is updated with <= so every flop samples pre-edge values;
  // the array has no reset so it maps onto LUT RAM rather than flops.
  always_ff @(posedge wr_clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Registered read port with its own synchronous clear.
    always_ff @(posedge rd_clk) begin
      if (rst)        r_rd_data <= '0;
      else if (rd_en) r_rd_data <= r_mem[rd_addr];
    end

    assign rd_data = r_rd_data;
  end else begin : g_comb_rd
    logic w_unused;
    assign w_unused = ^{rst, rd_clk};
    assign rd_data  = rd_en ? r_mem[rd_addr] : '0;
  end

  if (INIT_FILE != "NONE") begin : g_init_unsupported
    // Contents start undefined; buffered data is always written before read.
  end

endmodule

// File: rtl/ipsxe_fft_bitrev_pingpong_ctrl.sv
// Ping-pong input buffer for the FFT core. Natural-order samples fill one
// bank while the other bank is streamed out, in bit-reversed order when
// IPSXE_FFT_BITREV_EN is defined and in natural order otherwise.
module ipsxe_fft_bitrev_pingpong_ctrl
  import ipsxe_fft_bitrev_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_aclk,
  input  logic                  i_aresetn,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  o_err_last
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;
  localparam int                    BANK_BIT = ADDR_WIDTH - BANK_SEL_POS_FROM_MSB;

  logic [1:0]            r_full;
  logic                  r_wr_bank;
  logic [ADDR_WIDTH-1:0] r_wr_cnt;
  logic                  r_err_last;
  rd_state_e             r_state;
  logic                  r_rd_bank;
  logic [ADDR_WIDTH-1:0] r_rd_cnt;
  logic                  r_m_valid;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic                  r_m_last;

  logic                  w_wr_hs;
  logic                  w_wr_at_last;
  logic                  w_wr_wrap;
  logic                  w_load;
  logic                  w_rd_at_last;
  logic                  w_rd_wrap;
  logic [1:0]            w_full_nxt;
  logic [ADDR_WIDTH-1:0] w_rd_idx;
  logic [ADDR_WIDTH:0]   w_wr_addr;
  logic [ADDR_WIDTH:0]   w_rd_addr;
  logic [DATA_WIDTH-1:0] w_rd_data;

  assign s_ready      = ~r_full[r_wr_bank];
  assign w_wr_hs      = s_valid & s_ready;
  assign w_wr_at_last = (r_wr_cnt == LAST_IDX);
  assign w_wr_wrap    = w_wr_hs & w_wr_at_last;

  assign w_load       = (r_state == RUN) & (~r_m_valid | m_ready);
  assign w_rd_at_last = (r_rd_cnt == LAST_IDX);
  assign w_rd_wrap    = w_load & w_rd_at_last;

`ifdef IPSXE_FFT_BITREV_EN
  assign w_rd_idx = ADDR_WIDTH'(bitrev(MAX_ADDR_WIDTH'(r_rd_cnt), ADDR_WIDTH));
`else
  assign w_rd_idx = r_rd_cnt;
`endif

  // Bank flags after this cycle's events; the write side only ever sets the
  // bank it is filling and the read side only clears the bank it is draining.
  // NOTE: every combinational output gets a default first so no latch forms.
  always_comb begin
    w_full_nxt = r_full;
    if (w_wr_wrap) w_full_nxt[r_wr_bank] = 1'b1;
    if (w_rd_wrap) w_full_nxt[r_rd_bank] = 1'b0;
  end

  // Buffer addresses: bank select above the in-frame index.
  always_comb begin
    w_wr_addr                  = '0;
    w_wr_addr[ADDR_WIDTH-1:0]  = r_wr_cnt;
    w_wr_addr[BANK_BIT]        = r_wr_bank;
    w_rd_addr                  = '0;
    w_rd_addr[ADDR_WIDTH-1:0]  = w_rd_idx;
    w_rd_addr[BANK_BIT]        = r_rd_bank;
  end

  // Write side: count accepted samples, hand full banks over, flag s_last errors.
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_full     <= '0;
      r_wr_bank  <= 1'b0;
      r_wr_cnt   <= '0;
      r_err_last <= 1'b0;
    end else begin
      r_full     <= w_full_nxt;
      r_err_last <= w_wr_hs & (s_last != w_wr_at_last);
      if (w_wr_hs) begin
        r_wr_cnt <= r_wr_cnt + ADDR_WIDTH'(1);
        if (w_wr_at_last) r_wr_bank <= ~r_wr_bank;
      end
    end
  end

  // Read side: FSM, read counter and the registered output stage.
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_state   <= IDLE;
      r_rd_bank <= 1'b0;
      r_rd_cnt  <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_last  <= 1'b0;
    end else begin
      if (w_load) begin
        r_m_valid <= 1'b1;
        r_m_data  <= w_rd_data;
        r_m_last  <= w_rd_at_last;
        r_rd_cnt  <= r_rd_cnt + ADDR_WIDTH'(1);
        if (w_rd_at_last) r_rd_bank <= ~r_rd_bank;
      end else if (m_ready) begin
        r_m_valid <= 1'b0;
      end

      case (r_state)
        IDLE: if (w_full_nxt[r_rd_bank]) r_state <= RUN;
        RUN:  if (w_rd_wrap && !w_full_nxt[~r_rd_bank]) r_state <= IDLE;
      endcase
    end
  end

  assign m_valid    = r_m_valid;
  assign m_data     = r_m_data;
  assign m_last     = r_m_last;
  assign o_err_last = r_err_last;

  ipsxe_fft_distributed_sdpram_v1_2 #(
    .ADDR_WIDTH (ADDR_WIDTH + 1),
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_REG    (0),
    .INIT_FILE  ("NONE")
  ) u_sdpram (
    .wr_clk  (i_aclk),
    .rd_clk  (i_aclk),
    .rst     (1'b0),
    .wr_en   (w_wr_hs),
    .wr_addr (w_wr_addr),
    .wr_data (s_data),
    .rd_en   (1'b1),
    .rd_addr (w_rd_addr),
    .rd_data (w_rd_data)
  );

endmodule

// File: tb/tb_ipsxe_fft_bitrev_pingpong_ctrl.sv
// Scoreboard bench for the FFT ping-pong input buffer (N = 8).
module tb_ipsxe_fft_bitrev_pingpong_ctrl;

  localparam int AW = 3;
  localparam int DW = 32;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          err_last;

  always #5 clk = ~clk;

  ipsxe_fft_bitrev_pingpong_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .i_aclk     (clk),
    .i_aresetn  (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .o_err_last (err_last)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] cur_frame[$];

  int n_checks   = 0;
  int n_fail     = 0;
  int pops       = 0;
  int err_seen   = 0;
  int err_exp    = 0;
  int stall_cnt  = 0;
  int ready_mode = 0;
  int gaps       = 0;
  int gt         = 0;
  int acc        = 0;
  int base       = 0;
  int e0         = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Arithmetic bit reversal of a frame position.
  function automatic int rev_idx(input int k);
    int r = 0;
    int x = k;
    for (int i = 0; i < AW; i++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  // Which input position appears at output position k.
  function automatic int out_src(input int k);
`ifdef IPSXE_FFT_BITREV_EN
    return rev_idx(k);
`else
    return k;
`endif
  endfunction

  // Reference model: frames are delimited by count; a full frame produces N
  // expected outputs in read order.
  function automatic void model_accept(input logic [DW-1:0] d, input logic l);
    int pos = cur_frame.size();
    if ((l == 1'b1) != (pos == N - 1)) err_exp++;
    cur_frame.push_back(d);
    if (cur_frame.size() == N) begin
      for (int k = 0; k < N; k++) begin
        exp_t e;
        e.data = cur_frame[out_src(k)];
        e.last = (k == N - 1);
        exp_q.push_back(e);
      end
      cur_frame.delete();
    end
  endfunction

  // Downstream ready pattern: 0 = held low, 1 = held high, 2 = random.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       m_ready = 1'b0;
      1:       m_ready = 1'b1;
      default: m_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: compares every output handshake against the scoreboard queue,
  // checks that stalled outputs hold, and counts error pulses.
  initial begin : monitor
    exp_t          e;
    logic          held = 1'b0;
    logic [DW-1:0] hd   = '0;
    logic          hl   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("hold_valid", 64'(m_valid), 64'(1));
          check("hold_data",  64'(m_data),  64'(hd));
          check("hold_last",  64'(m_last),  64'(hl));
        end
        if (err_last) err_seen++;
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got data %0h, expected no output", m_data);
          end else begin
            e = exp_q.pop_front();
            check("out_data", 64'(m_data), 64'(e.data));
            check("out_last", 64'(m_last), 64'(e.last));
          end
          pops++;
        end
        held = m_valid && !m_ready;
        hd   = m_data;
        hl   = m_last;
      end
    end
  end

  // Present one sample and hold it until accepted; returns just after the
  // accepting edge.
  task automatic send(input logic [DW-1:0] d, input logic l);
    int  t   = 0;
    bit  got = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!got) begin
      @(negedge clk);
      if (s_ready) begin
        got = 1'b1;
        model_accept(d, l);
      end else begin
        stall_cnt++;
      end
      @(posedge clk);
      #1;
      if (!got) begin
        t++;
        if (t > 300) begin
          timeout_fail("send");
          got = 1'b1;
        end
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 400 && exp_q.size() > 0; t++) begin
      @(posedge clk);
      #1;
    end
    check(name, 64'(exp_q.size()), 64'(0));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    // Reset state.
    idle(3);
    check("rst_m_valid",  64'(m_valid),  64'(0));
    check("rst_m_data",   64'(m_data),   64'(0));
    check("rst_m_last",   64'(m_last),   64'(0));
    check("rst_err_last", 64'(err_last), 64'(0));
    check("rst_s_ready",  64'(s_ready),  64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    check("post_rst_s_ready", 64'(s_ready), 64'(1));

    // Single frame 0..7: latency and order.
    ready_mode = 1;
    idle(1);
    for (int i = 0; i < N; i++) send(DW'(i), (i == N - 1));
    check("lat_edge_e_m_valid", 64'(m_valid), 64'(0));
    idle(1);
    check("lat_edge_e1_m_valid", 64'(m_valid), 64'(1));
    check("lat_edge_e1_m_data",  64'(m_data),  64'(0));
    drain("drain_single");
    check("single_m_valid_low", 64'(m_valid), 64'(0));

    // Three back-to-back frames with continuous flow.
    stall_cnt = 0;
    gaps      = 0;
    base      = pops;
    fork
      begin
        for (int i = 0; i < 3 * N; i++) send($urandom, ((i % N) == N - 1));
      end
      begin
        gt = 0;
        do begin
          @(negedge clk);
          #1;
          gt++;
        end while (!m_valid && gt < 100);
        while (pops < base + 3 * N && gt < 300) begin
          if (!m_valid) gaps++;
          @(negedge clk);
          #1;
          gt++;
        end
        if (gt >= 300) timeout_fail("stream_outputs");
      end
    join
    check("stream_s_ready_stalls", 64'(stall_cnt), 64'(0));
    check("stream_m_valid_gaps",   64'(gaps),      64'(0));
    drain("drain_stream");

    // Backpressure: downstream stalled, 20 input attempts.
    ready_mode = 0;
    idle(2);
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      s_valid = 1'b1;
      s_data  = DW'(32'h100 + acc);
      s_last  = ((acc % N) == N - 1);
      @(negedge clk);
      check("bp_s_ready", 64'(s_ready), 64'(acc < 2 * N));
      if (s_ready) begin
        model_accept(s_data, s_last);
        acc++;
      end
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("bp_accepted", 64'(acc), 64'(2 * N));
    ready_mode = 1;
    drain("drain_bp");

    // Misplaced frame marker: early on sample 5, missing on sample 7.
    e0 = err_seen;
    for (int i = 0; i < N; i++) send(DW'(32'h200 + i), (i == 5));
    drain("drain_err");
    idle(2);
    check("err_pulse_count", 64'(err_seen - e0), 64'(2));

    // Random traffic, random backpressure, occasional marker errors.
    ready_mode = 2;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < N; i++) begin
        send($urandom, ((i == N - 1) ^ ($urandom_range(0, 15) == 0)));
        idle($urandom_range(0, 2));
      end
    end
    ready_mode = 1;
    drain("drain_random");
    idle(2);
    check("err_total", 64'(err_seen), 64'(err_exp));

    // Reset in the middle of a read-out.
    for (int i = 0; i < N; i++) send(DW'(32'h300 + i), (i == N - 1));
    base = pops;
    for (int t = 0; t < 100 && pops < base + 3; t++) begin
      @(negedge clk);
      #1;
    end
    if (pops < base + 3) timeout_fail("mid_read_outputs");
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_m_valid", 64'(m_valid), 64'(0));
    check("mid_rst_s_ready", 64'(s_ready), 64'(1));
    check("mid_rst_m_last",  64'(m_last),  64'(0));
    check("mid_rst_m_data",  64'(m_data),  64'(0));
    exp_q.delete();
    cur_frame.delete();
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    check("mid_rst_release_s_ready", 64'(s_ready), 64'(1));
    for (int i = 0; i < N; i++) send($urandom, (i == N - 1));
    drain("drain_after_reset");
    check("after_reset_m_valid_low", 64'(m_valid), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
